// File: rtl/operand2_shifter_pipe.sv
// operand2_shifter_pipe: two-stage pipelined operand-2 generator.
// Stage 1 decodes the addressing mode and the effective shift amount.
// Stage 2 runs the barrel shifter and the carry logic, then registers
// val_2 and carry_out. A valid/ready handshake provides backpressure,
// and flush kills both stages.
module operand2_shifter_pipe #(
    parameter int DATA_W = 32,
    parameter int IMM_W  = 8,
    parameter int OFFS_W = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] rm,
    input  logic [DATA_W-1:0] rs,
    input  logic [11:0]       shift_operand,
    input  logic              imm,
    input  logic              select,
    input  logic              carry_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] val_2,
    output logic              carry_out
);

    localparam int         SH_W = $clog2(DATA_W);
    localparam logic [7:0] W_N  = 8'(DATA_W);

    localparam logic [1:0] MODE_OFFSET    = 2'd0;
    localparam logic [1:0] MODE_ROT_IMM   = 2'd1;
    localparam logic [1:0] MODE_SHIFT_IMM = 2'd2;
    localparam logic [1:0] MODE_SHIFT_REG = 2'd3;

    localparam logic [1:0] TYPE_LSL = 2'd0;
    localparam logic [1:0] TYPE_LSR = 2'd1;
    localparam logic [1:0] TYPE_ASR = 2'd2;
    localparam logic [1:0] TYPE_ROR = 2'd3;

    // Rotate right. Shifting left by (-a mod W) gives the wrapped bits;
    // when a is 0 both terms equal x, so the OR still returns x.
    function automatic logic [DATA_W-1:0] rotr(input logic [DATA_W-1:0] x,
                                               input logic [SH_W-1:0]   a);
        logic [SH_W-1:0] a_neg;
        a_neg = SH_W'(0) - a;
        return (x >> a) | (x << a_neg);
    endfunction

    // Only the low byte of rs is used as a shift amount.
    generate
        if (DATA_W > 8) begin : g_rs_hi
            logic unused_rs_hi;
            assign unused_rs_hi = |rs[DATA_W-1:8];
        end
    endgenerate

    // Handshake and stage-advance controls
    logic v1_q, v1_d, v2_q, v2_d;
    logic adv1, adv2, take, load2;

    assign adv2     = !v2_q | out_ready;
    assign adv1     = !v1_q | adv2;
    assign in_ready = adv1 & !flush;
    assign take     = in_valid & in_ready;
    assign load2    = adv2 & v1_q & !flush;

    // Stage-1 registers
    logic [DATA_W-1:0] rm_q;
    logic              cin_q;
    logic [1:0]        mode_q, mode_d;
    logic [1:0]        type_q, type_d;
    logic [7:0]        n_q, n_d;
    logic              rrx_q, rrx_d;
    logic [11:0]       op_q;

    // Stage-2 registers
    logic [DATA_W-1:0] val_q, val_d;
    logic              c_q, c_d;

    // Mode priority and effective shift amount, including the #0 special cases
    always_comb begin
        mode_d = MODE_SHIFT_REG;
        type_d = shift_operand[6:5];
        n_d    = 8'd0;
        rrx_d  = 1'b0;
        if (select)
            mode_d = MODE_OFFSET;
        else if (imm)
            mode_d = MODE_ROT_IMM;
        else if (!shift_operand[4])
            mode_d = MODE_SHIFT_IMM;

        if (mode_d == MODE_SHIFT_IMM) begin
            n_d = {3'b000, shift_operand[11:7]};
            if (shift_operand[11:7] == 5'd0) begin
                if (type_d == TYPE_LSR || type_d == TYPE_ASR)
                    n_d = W_N;
                else if (type_d == TYPE_ROR)
                    rrx_d = 1'b1;
            end
        end else if (mode_d == MODE_SHIFT_REG) begin
            n_d = rs[7:0];
        end
    end

    // Valid bits for both stages; flush overrides every handshake
    always_comb begin
        v1_d = v1_q;
        v2_d = v2_q;
        if (flush) begin
            v1_d = 1'b0;
            v2_d = 1'b0;
        end else begin
            if (adv1) v1_d = take;
            if (adv2) v2_d = v1_q;
        end
    end

    // Shifter and carry generation from the stage-1 registers
    logic [SH_W-1:0]   k, k_dec, k_neg, rot_amt;
    logic [DATA_W-1:0] imm_ext, rot_val;
    logic              n_lt_w, n_eq_w;

    always_comb begin
        val_d   = rm_q;
        c_d     = cin_q;
        k       = n_q[SH_W-1:0];
        k_dec   = k - SH_W'(1);
        k_neg   = SH_W'(0) - k;
        n_lt_w  = n_q < W_N;
        n_eq_w  = n_q == W_N;
        rot_amt = SH_W'({op_q[11:8], 1'b0});
        imm_ext = DATA_W'(op_q[IMM_W-1:0]);
        rot_val = rotr(imm_ext, rot_amt);

        case (mode_q)
            MODE_OFFSET: begin
                val_d = DATA_W'(op_q[OFFS_W-1:0]);
                c_d   = cin_q;
            end
            MODE_ROT_IMM: begin
                val_d = rot_val;
                c_d   = (op_q[11:8] == 4'd0) ? cin_q : rot_val[DATA_W-1];
            end
            default: begin
                if (rrx_q) begin
                    val_d = {cin_q, rm_q[DATA_W-1:1]};
                    c_d   = rm_q[0];
                end else if (n_q != 8'd0) begin
                    case (type_q)
                        TYPE_LSL: begin
                            if (n_lt_w) begin
                                val_d = rm_q << k;
                                c_d   = rm_q[k_neg];
                            end else begin
                                val_d = '0;
                                c_d   = n_eq_w ? rm_q[0] : 1'b0;
                            end
                        end
                        TYPE_LSR: begin
                            if (n_lt_w) begin
                                val_d = rm_q >> k;
                                c_d   = rm_q[k_dec];
                            end else begin
                                val_d = '0;
                                c_d   = n_eq_w ? rm_q[DATA_W-1] : 1'b0;
                            end
                        end
                        TYPE_ASR: begin
                            if (n_lt_w) begin
                                val_d = $unsigned($signed(rm_q) >>> k);
                                c_d   = rm_q[k_dec];
                            end else begin
                                val_d = {DATA_W{rm_q[DATA_W-1]}};
                                c_d   = rm_q[DATA_W-1];
                            end
                        end
                        default: begin
                            if (k == '0) begin
                                val_d = rm_q;
                                c_d   = rm_q[DATA_W-1];
                            end else begin
                                val_d = rotr(rm_q, k);
                                c_d   = rm_q[k_dec];
                            end
                        end
                    endcase
                end
            end
        endcase
    end

    // Pipeline valid flags
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v1_q <= 1'b0;
            v2_q <= 1'b0;
        end else begin
            v1_q <= v1_d;
            v2_q <= v2_d;
        end
    end

    // Stage-1 decode registers, loaded on an accepted request
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rm_q   <= '0;
            cin_q  <= 1'b0;
            mode_q <= MODE_OFFSET;
            type_q <= TYPE_LSL;
            n_q    <= 8'd0;
            rrx_q  <= 1'b0;
            op_q   <= 12'd0;
        end else if (take) begin
            rm_q   <= rm;
            cin_q  <= carry_in;
            mode_q <= mode_d;
            type_q <= type_d;
            n_q    <= n_d;
            rrx_q  <= rrx_d;
            op_q   <= shift_operand;
        end
    end

    // Stage-2 result registers; held while the consumer stalls
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            val_q <= '0;
            c_q   <= 1'b0;
        end else if (load2) begin
            val_q <= val_d;
            c_q   <= c_d;
        end
    end

    assign out_valid = v2_q;
    assign val_2     = val_q;
    assign carry_out = c_q;

endmodule

// File: tb/tb_operand2_shifter_pipe.sv
// Testbench for operand2_shifter_pipe: scoreboard-driven, one line per result.
module tb_operand2_shifter_pipe;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready;
    logic [31:0] rm, rs;
    logic [11:0] shift_operand;
    logic        imm, select, carry_in;
    logic        out_valid, out_ready;
    logic [31:0] val_2;
    logic        carry_out;

    operand2_shifter_pipe dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .rm(rm), .rs(rs), .shift_operand(shift_operand),
        .imm(imm), .select(select), .carry_in(carry_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .val_2(val_2), .carry_out(carry_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          id;
        logic [31:0] v;
        logic        c;
        int          acc;
        bit          lat;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fails  = 0;
    int   cyc      = 0;
    int   next_id  = 0;
    int   last_acc = 0;
    int   delivered = 0;
    bit   bp_en = 1'b0;
    bit   stream_phase = 1'b0;
    bit   blocked_seen = 1'b0;
    bit   stall_prev = 1'b0;
    logic [31:0] held_v;
    logic        held_c;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Independent reference model for a 32-bit datapath, returns {C, val_2}
    function automatic logic [32:0] model(input logic [31:0] r, input logic [31:0] s,
                                          input logic [11:0] op, input logic im,
                                          input logic sl, input logic ci);
        int n, k, t;
        logic [31:0] v;
        logic c;
        if (sl) return {ci, 20'd0, op};
        if (im) begin
            t = 2 * int'(op[11:8]);
            v = {24'd0, op[7:0]};
            if (t != 0) v = (v >> t) | (v << (32 - t));
            c = (t == 0) ? ci : v[31];
            return {c, v};
        end
        t = int'(op[6:5]);
        if (!op[4]) begin
            n = int'(op[11:7]);
            if (n == 0) begin
                if (t == 3) return {r[0], ci, r[31:1]};
                if (t == 1 || t == 2) n = 32;
            end
        end else begin
            n = int'(s[7:0]);
        end
        if (n == 0) return {ci, r};
        case (t)
            0: begin
                if (n < 32) return {r[32-n], r << n};
                if (n == 32) return {r[0], 32'd0};
                return 33'd0;
            end
            1: begin
                if (n < 32) return {r[n-1], r >> n};
                if (n == 32) return {r[31], 32'd0};
                return 33'd0;
            end
            2: begin
                if (n < 32) return {r[n-1], 32'($signed(r) >>> n)};
                return {r[31], {32{r[31]}}};
            end
            default: begin
                k = n % 32;
                if (k == 0) return {r[31], r};
                return {r[k-1], (r >> k) | (r << (32 - k))};
            end
        endcase
        return 33'd0;
    endfunction

    // Random backpressure when enabled
    always @(posedge clk) begin
        #1;
        if (bp_en) out_ready = ($urandom_range(0, 3) != 0);
    end

    // Output monitor: pops the scoreboard and checks hold-while-stalled
    always @(negedge clk) begin
        exp_t e;
        if (stream_phase && !in_ready) blocked_seen = 1'b1;
        if (rst && out_valid && !out_ready) begin
            if (stall_prev) begin
                check("hold_val", {32'd0, val_2}, {32'd0, held_v});
                check("hold_c", {63'd0, carry_out}, {63'd0, held_c});
            end
            held_v = val_2;
            held_c = carry_out;
            stall_prev = 1'b1;
        end else begin
            stall_prev = 1'b0;
        end
        if (rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("spurious_out", 64'd1, 64'd0);
            end else begin
                e = sb.pop_front();
                delivered++;
                $display("res %0d: val_2=0x%08h C=%0b exp 0x%08h C=%0b", e.id, val_2, carry_out, e.v, e.c);
                check($sformatf("val_%0d", e.id), {32'd0, val_2}, {32'd0, e.v});
                check($sformatf("c_%0d", e.id), {63'd0, carry_out}, {63'd0, e.c});
                if (e.lat) check("latency", 64'(cyc - e.acc), 64'd2);
            end
        end
    end

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    // Drive one request (called at posedge+1); push expectation on acceptance
    task automatic send(input logic [31:0] a_rm, input logic [31:0] a_rs,
                        input logic [11:0] a_op, input logic a_imm, input logic a_sel,
                        input logic a_cin, input logic [31:0] e_v, input logic e_c,
                        input bit lat);
        int waited;
        exp_t e;
        in_valid = 1'b1; rm = a_rm; rs = a_rs; shift_operand = a_op;
        imm = a_imm; select = a_sel; carry_in = a_cin;
        waited = 0;
        @(negedge clk);
        while (!in_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            check("accept_timeout", 64'd0, 64'd1);
        end else begin
            e.id = next_id; e.v = e_v; e.c = e_c; e.acc = cyc; e.lat = lat;
            sb.push_back(e);
            next_id++;
            last_acc = cyc;
        end
        sync();
        in_valid = 1'b0;
    endtask

    task automatic send_model(input logic [31:0] a_rm, input logic [31:0] a_rs,
                              input logic [11:0] a_op, input logic a_imm,
                              input logic a_sel, input logic a_cin);
        logic [32:0] m;
        m = model(a_rm, a_rs, a_op, a_imm, a_sel, a_cin);
        send(a_rm, a_rs, a_op, a_imm, a_sel, a_cin, m[31:0], m[32], 1'b0);
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while (sb.size() != 0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (sb.size() != 0) check("drain_timeout", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        int prev, d0;
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        rm = '0; rs = '0; shift_operand = '0; imm = 1'b0; select = 1'b0; carry_in = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_val_2", {32'd0, val_2}, 64'd0);
        check("rst_carry", {63'd0, carry_out}, 64'd0);
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        #2 rst = 1'b1;
        @(negedge clk);
        check("rst_in_ready", {63'd0, in_ready}, 64'd1);
        sync();

        // Directed cases with constant expectations
        send(32'h0, 32'h0, 12'h4FF, 1'b1, 1'b0, 1'b0, 32'hFF000000, 1'b1, 1'b1);
        send(32'h80000001, 32'h0, 12'h020, 1'b0, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0);
        send(32'h80000001, 32'h0, 12'h040, 1'b0, 1'b0, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b0);
        send(32'h80000001, 32'h0, 12'h060, 1'b0, 1'b0, 1'b0, 32'h40000000, 1'b1, 1'b0);
        send(32'h0000000F, 32'd32, 12'h010, 1'b0, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0);
        send(32'h0000000F, 32'd33, 12'h010, 1'b0, 1'b0, 1'b1, 32'h00000000, 1'b0, 1'b0);
        send(32'h0000000F, 32'd36, 12'h070, 1'b0, 1'b0, 1'b0, 32'hF0000000, 1'b1, 1'b0);
        send(32'h0000000F, 32'h100, 12'h070, 1'b0, 1'b0, 1'b1, 32'h0000000F, 1'b1, 1'b0);
        send(32'h12345678, 32'h0, 12'hABC, 1'b1, 1'b1, 1'b1, 32'h00000ABC, 1'b1, 1'b0);
        wait_drain();
        sync();

        // Throughput: back-to-back accepts with out_ready held high
        for (int i = 0; i < 6; i++) begin
            prev = last_acc;
            send_model($urandom, 32'($urandom_range(0, 40)), 12'($urandom_range(0, 4095)),
                       1'b0, 1'b0, 1'($urandom_range(0, 1)));
            if (i > 0) check("throughput", 64'(last_acc - prev), 64'd1);
        end
        wait_drain();
        sync();

        // Streaming with a stall window
        d0 = delivered;
        stream_phase = 1'b1;
        blocked_seen = 1'b0;
        fork
            begin
                repeat (2) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (4) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join_none
        for (int i = 0; i < 5; i++)
            send_model(32'h11111111 * (i + 1), 32'(i + 1), 12'h010 | 12'(i << 5),
                       1'b0, 1'b0, 1'b0);
        wait_drain();
        stream_phase = 1'b0;
        check("stream_in_ready_low", {63'd0, blocked_seen}, 64'd1);
        check("stream_count", 64'(delivered - d0), 64'd5);
        sync();

        // Random traffic with random backpressure
        bp_en = 1'b1;
        for (int i = 0; i < 24; i++)
            send_model($urandom, ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 70)),
                       12'($urandom_range(0, 4095)), 1'($urandom_range(0, 3) == 0),
                       1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)));
        wait_drain();
        bp_en = 1'b0;
        sync();
        out_ready = 1'b1;

        // Flush with both stages full and a request pending
        out_ready = 1'b0;
        send_model(32'hA5A5A5A5, 32'd4, 12'h010, 1'b0, 1'b0, 1'b0);
        send_model(32'h5A5A5A5A, 32'd8, 12'h030, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        check("full_out_valid", {63'd0, out_valid}, 64'd1);
        check("full_in_ready", {63'd0, in_ready}, 64'd0);
        sync();
        in_valid = 1'b1; rm = 32'hDEADBEEF; rs = 32'd1; shift_operand = 12'h010;
        flush = 1'b1;
        @(negedge clk);
        check("flush_in_ready", {63'd0, in_ready}, 64'd0);
        sb.delete();
        sync();
        flush = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("flush_out_valid", {63'd0, out_valid}, 64'd0);
        out_ready = 1'b1;
        repeat (5) @(negedge clk);
        check("flush_no_output", {63'd0, out_valid}, 64'd0);
        sync();

        // Asynchronous reset between clock edges
        out_ready = 1'b0;
        send(32'h0, 32'h0, 12'h4FF, 1'b1, 1'b0, 1'b0, 32'hFF000000, 1'b1, 1'b0);
        repeat (2) @(negedge clk);
        check("pre_rst_out_valid", {63'd0, out_valid}, 64'd1);
        #2 rst = 1'b0;
        #1;
        check("async_val_2", {32'd0, val_2}, 64'd0);
        check("async_carry", {63'd0, carry_out}, 64'd0);
        check("async_out_valid", {63'd0, out_valid}, 64'd0);
        sb.delete();
        @(negedge clk);
        #2 rst = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready", {63'd0, in_ready}, 64'd1);
        check("post_rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("sb_empty", 64'(sb.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    // Global time limit
    initial begin
        #200000;
        $display("FAIL global_timeout: got 0x0 expected 0x1");
        $fatal(1, "time limit");
    end

endmodule

// File: doc/operand2_shifter_pipe.md
Name: operand2_shifter_pipe

Overview:
- Parametrised, 2-stage pipelined successor to the combinational operand-2 generator in the execute path.
- Produces the second ALU operand (val_2) and the shifter carry-out.
- Adds register-specified shifts (amount from Rs), ARM special cases (LSR/ASR #0 = #W, ROR #0 = RRX), carry generation, valid/ready handshake with backpressure, and pipeline flush.

Parameters:
- DATA_W, 32: operand width; power of two, 8..64.
- IMM_W, 8: rotated-immediate field width (shift_operand[IMM_W-1:0]).
- OFFS_W, 12: memory offset width; zero-extended to DATA_W.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous pipeline kill.
- in_valid  in  1  request valid.
- in_ready  out  1  unit can accept the request this cycle.
- rm  in  DATA_W  value to shift.
- rs  in  DATA_W  shift register; only rs[7:0] is used.
- shift_operand  in  12  instruction operand field.
- imm  in  1  immediate (rotate) form.
- select  in  1  memory-offset form (LDR/STR).
- carry_in  in  1  current CPSR C flag.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- val_2  out  DATA_W  operand 2.
- carry_out  out  1  shifter carry.

Behaviour:
- Reset (rst=0, asynchronous): both stage valids=0, all stage registers=0. val_2=0, carry_out=0, out_valid=0. in_ready=1 after release.
- Mode priority: select=1 -> OFFSET; else imm=1 -> ROT_IMM; else shift_operand[4]=0 -> SHIFT_IMM; else SHIFT_REG.
- Field decode:
  - type = shift_operand[6:5] (00 LSL, 01 LSR, 10 ASR, 11 ROR).
  - shift_imm = shift_operand[11:7].
  - rot = shift_operand[11:8].
- Stage 1 (decode) registers: rm, carry_in, mode, type, 8-bit effective amount n.
  - SHIFT_IMM: n = shift_imm, except LSR/ASR with 0 -> n = DATA_W.
  - SHIFT_IMM ROR with 0 -> RRX flag set.
  - SHIFT_REG: n = rs[7:0].
- Stage 2 (execute) registers val_2 and carry_out. Outputs come directly from stage-2 registers.
- OFFSET: val_2 = zero-extend shift_operand[OFFS_W-1:0]; C = carry_in.
- ROT_IMM: val_2 = zero-extended imm8 rotated right by (2*rot) mod DATA_W.
  - C = carry_in if rot=0, else val_2[DATA_W-1].
- For every shift type, n=0 gives val_2=rm, C=carry_in.
- LSL:
  - 0<n<W: rm<<n, C = rm[W-n].
  - n=W: 0, C = rm[0].
  - n>W: 0, C = 0.
- LSR:
  - 0<n<W: rm>>n, C = rm[n-1].
  - n=W: 0, C = rm[W-1].
  - n>W: 0, C = 0.
- ASR:
  - 0<n<W: arithmetic right shift, C = rm[n-1].
  - n>=W: all bits = rm[W-1], C = rm[W-1].
- ROR:
  - k = n mod W.
  - k=0, n>0: val_2 = rm, C = rm[W-1].
  - else rotate right by k, C = rm[k-1].
- RRX: val_2 = {carry_in, rm[W-1:1]}, C = rm[0].
- Handshake and stage advance:
  - adv2 = !v2 | out_ready.
  - adv1 = !v1 | adv2.
  - in_ready = adv1 & !flush.
  - Stage 1 loads on in_valid & in_ready.
  - Stage 2 loads from stage 1 when adv2.
  - out_valid = v2.
- Latency: 2 cycles from accept to out_valid. Throughput: 1 per cycle with out_ready held high.
- Backpressure: while out_ready=0 and out_valid=1, val_2 and carry_out are held stable. Stage 1 fills, then in_ready drops.
- Flush: clears v1 and v2 next edge and drops any input in the same cycle. flush has priority over all handshakes. Data registers are not cleared.
- Reset asserted mid-operation: in-flight ops are lost, outputs go to 0 immediately.

Test Plan:
- ROT_IMM: shift_operand=0x4FF (rot=4, imm=0xFF), carry_in=0 -> val_2=0xFF000000, C=1, out_valid exactly 2 cycles after accept.
- SHIFT_IMM: rm=0x80000001.
  - LSR #0 -> val_2=0, C=1.
  - ASR #0 -> 0xFFFFFFFF, C=1.
  - ROR #0 with carry_in=0 (RRX) -> 0x40000000, C=1.
- SHIFT_REG: rm=0x0000000F.
  - LSL by rs=32 -> 0, C=1.
  - LSL by rs=33 -> 0, C=0.
  - ROR by rs=36 -> 0xF0000000, C=1.
  - rs=0x100 (low byte 0) -> rm, C=carry_in.
- OFFSET: select=1, shift_operand=0xABC, imm=1 -> val_2=0x00000ABC (select wins), C=carry_in.
- Streaming: 5 back-to-back requests with out_ready=0 for cycles 3-6.
  - in_ready low once both stages are full.
  - Outputs stable while stalled.
  - All 5 results delivered in order, none lost or duplicated.
- Flush and reset:
  - flush with in_valid=1 and both stages full -> out_valid=0 next cycle, nothing emitted.
  - Async rst pulse between edges -> val_2, carry_out and out_valid go to 0 without a clock edge.
